reg_file_scoreboard: RTL

//   Parametrised register file for the 5-stage pipeline, with an integrated write scoreboard.
//   - Read ports: 2, combinational, with write-through bypass.
//   - Write port: 1, used at writeback.
//   - Decode claims a destination register when an instruction issues; writeback releases it.
//   - The block raises stall on any RAW hazard that the bypass cannot cover.

---
 rtl/reg_file_scoreboard.sv | 105 ++++++++++
 1 files changed

// File: rtl/reg_file_scoreboard.sv
// Register file with two bypassed combinational read ports, one writeback port,
// and a per-register outstanding-write scoreboard that raises stall on RAW hazards.
module reg_file_scoreboard #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter bit          BYPASS       = 1'b1,
  parameter bit          ZERO_REG     = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              rd_used0,
  input  logic              rd_used1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic              stall,
  output logic              err
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam int unsigned CNT_W    = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [CNT_W-1:0]  r_cnt  [NUM_REGS];
  logic              r_err;

  logic                w_wr_en;
  logic                w_busy0;
  logic                w_busy1;
  logic                w_full;
  logic                w_claim_acc;
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;

  // R0 writes are dropped entirely when it is hardwired to zero
  assign w_wr_en = we && !(ZERO_REG && (waddr == '0));

  // Read ports with same-cycle write forwarding
  always_comb begin
    rdata0 = r_regs[raddr0];
    rdata1 = r_regs[raddr1];
    if (BYPASS && we && (waddr == raddr0)) rdata0 = wdata;
    if (BYPASS && we && (waddr == raddr1)) rdata1 = wdata;
    if (ZERO_REG && (raddr0 == '0)) rdata0 = '0;
    if (ZERO_REG && (raddr1 == '0)) rdata1 = '0;
  end

  // Hazard detection: a last outstanding write landing this cycle is covered by the bypass
  always_comb begin
    w_busy0 = (r_cnt[raddr0] != '0);
    w_busy1 = (r_cnt[raddr1] != '0);
    if (BYPASS && we && (waddr == raddr0) && (r_cnt[raddr0] == CNT_ONE)) w_busy0 = 1'b0;
    if (BYPASS && we && (waddr == raddr1) && (r_cnt[raddr1] == CNT_ONE)) w_busy1 = 1'b0;
    if (ZERO_REG && (raddr0 == '0)) w_busy0 = 1'b0;
    if (ZERO_REG && (raddr1 == '0)) w_busy1 = 1'b0;
    w_full      = claim_en && (r_cnt[claim_addr] == CNT_MAX);
    stall       = (rd_used0 && w_busy0) || (rd_used1 && w_busy1) || w_full;
    w_claim_acc = claim_en && !stall && !flush && !(ZERO_REG && (claim_addr == '0));
  end

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_inc[i] = w_claim_acc && (claim_addr == ADDR_W'(i));
      w_dec[i] = w_wr_en && (waddr == ADDR_W'(i));
    end
  end

  // Register storage, scoreboard counters and sticky underflow flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_err <= 1'b0;
    end else begin
      if (w_wr_en) r_regs[waddr] <= wdata;
      if (w_wr_en && (r_cnt[waddr] == '0)) r_err <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (flush) begin
          r_cnt[i] <= '0;
        end else if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end
      end
    end
  end

  assign err = r_err;

endmodule
